// File: rtl/pwm_ctrl.sv
// Multi-channel PWM slave: zero-wait-state register access, shared prescaler/period counter,
// double-buffered period/duties loaded at period boundaries; pwm_out registered (1 clk lag).
module pwm_ctrl #(
   parameter int         CHANNELS     = 8,
   parameter logic [7:0] RESET_PERIOD = 8'd255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         address_in,
   input  logic                sel_in,
   input  logic                read_in,
   output logic [31:0]         read_value_out,
   input  logic [3:0]          write_mask_in,
   input  logic [31:0]         write_value_in,
   output logic                ready_out,
   output logic [CHANNELS-1:0] pwm_out
);

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_PERIOD = 3'd1;
   localparam logic [2:0] REG_DUTY0  = 3'd2;
   localparam logic [2:0] REG_DUTY1  = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   logic                enable_q, enable_d;
   logic [15:0]         prescale_q, prescale_d;
   logic [7:0]          period_sh_q, period_sh_d;
   logic [7:0]          period_act_q, period_act_d;
   logic [7:0]          duty_sh_q [8];
   logic [7:0]          duty_sh_d [8];
   logic [7:0]          duty_act_q [8];
   logic [7:0]          duty_act_d [8];
   logic [15:0]         presc_cnt_q, presc_cnt_d;
   logic [7:0]          counter_q, counter_d;
   logic                pending_q, pending_d;
   logic [CHANNELS-1:0] pwm_q, pwm_d;

   logic [2:0] reg_idx;
   logic       wr_en;
   logic       pd_write;
   logic       run;
   logic       tick;
   logic       boundary;
   logic       unused_bits;

   assign reg_idx     = address_in[4:2];
   assign wr_en       = sel_in && (write_mask_in != 4'b0000);
   assign pd_write    = wr_en && (reg_idx inside {REG_PERIOD, REG_DUTY0, REG_DUTY1});
   assign unused_bits = ^{address_in[31:5], address_in[1:0], read_in};

   // Register writes; duty lanes for channels that do not exist are never stored.
   always_comb begin
      enable_d    = enable_q;
      prescale_d  = prescale_q;
      period_sh_d = period_sh_q;
      duty_sh_d   = duty_sh_q;
      if (wr_en) begin
         case (reg_idx)
            REG_CTRL: begin
               if (write_mask_in[0]) enable_d         = write_value_in[0];
               if (write_mask_in[2]) prescale_d[7:0]  = write_value_in[23:16];
               if (write_mask_in[3]) prescale_d[15:8] = write_value_in[31:24];
            end
            REG_PERIOD: begin
               if (write_mask_in[0]) period_sh_d = write_value_in[7:0];
            end
            REG_DUTY0, REG_DUTY1: begin
               for (int b = 0; b < 4; b++) begin
                  if (write_mask_in[b] && (int'(reg_idx[0]) * 4 + b < CHANNELS))
                     duty_sh_d[{reg_idx[0], 2'(b)}] = write_value_in[8*b +: 8];
               end
            end
            default: ;
         endcase
      end
   end

   // A disabling write stops the timebase at the same edge, so pwm and counter clear immediately.
   assign run      = enable_q && enable_d;
   assign tick     = run && (presc_cnt_q == prescale_q);
   assign boundary = tick && (counter_q == period_act_q);

   always_comb begin
      presc_cnt_d  = presc_cnt_q;
      counter_d    = counter_q;
      period_act_d = period_act_q;
      duty_act_d   = duty_act_q;
      pending_d    = pending_q;
      pwm_d        = '0;
      if (!run) begin
         presc_cnt_d  = '0;
         counter_d    = '0;
         period_act_d = period_sh_q;
         duty_act_d   = duty_sh_q;
         pending_d    = 1'b0;
      end else begin
         presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
         if (tick) counter_d = boundary ? 8'd0 : counter_q + 8'd1;
         if (boundary) begin
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
         end
         pending_d = pd_write || (pending_q && !boundary);
         for (int i = 0; i < CHANNELS; i++) pwm_d[i] = counter_q < duty_act_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable_q     <= 1'b0;
         prescale_q   <= '0;
         period_sh_q  <= RESET_PERIOD;
         period_act_q <= RESET_PERIOD;
         for (int i = 0; i < 8; i++) begin
            duty_sh_q[i]  <= '0;
            duty_act_q[i] <= '0;
         end
         presc_cnt_q  <= '0;
         counter_q    <= '0;
         pending_q    <= 1'b0;
         pwm_q        <= '0;
      end else begin
         enable_q     <= enable_d;
         prescale_q   <= prescale_d;
         period_sh_q  <= period_sh_d;
         period_act_q <= period_act_d;
         duty_sh_q    <= duty_sh_d;
         duty_act_q   <= duty_act_d;
         presc_cnt_q  <= presc_cnt_d;
         counter_q    <= counter_d;
         pending_q    <= pending_d;
         pwm_q        <= pwm_d;
      end
   end

   always_comb begin
      read_value_out = '0;
      if (sel_in) begin
         case (reg_idx)
            REG_CTRL:   read_value_out = {prescale_q, 15'd0, enable_q};
            REG_PERIOD: read_value_out = {24'd0, period_sh_q};
            REG_DUTY0:  read_value_out = {duty_sh_q[3], duty_sh_q[2], duty_sh_q[1], duty_sh_q[0]};
            REG_DUTY1:  read_value_out = {duty_sh_q[7], duty_sh_q[6], duty_sh_q[5], duty_sh_q[4]};
            REG_STATUS: read_value_out = {16'd0, counter_q, 7'd0, pending_q};
            default:    read_value_out = '0;
         endcase
      end
   end

   assign ready_out = sel_in;
   assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: register table, hand-written timing sequences, randomized traffic
// checked against an elapsed-time reference model.
module tb_pwm_ctrl;
   localparam int NCH = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [31:0]    address_in;
   logic           sel_in;
   logic           read_in;
   logic [31:0]    read_value_out;
   logic [3:0]     write_mask_in;
   logic [31:0]    write_value_in;
   logic           ready_out;
   logic [NCH-1:0] pwm_out;

   pwm_ctrl #(.CHANNELS(NCH), .RESET_PERIOD(8'hFF)) dut (
      .clk            (clk),
      .reset          (reset),
      .address_in     (address_in),
      .sel_in         (sel_in),
      .read_in        (read_in),
      .read_value_out (read_value_out),
      .write_mask_in  (write_mask_in),
      .write_value_in (write_value_in),
      .ready_out      (ready_out),
      .pwm_out        (pwm_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the timebase is tracked as clocks elapsed within the current period.
   logic           m_en;
   logic [15:0]    m_S;
   logic [7:0]     m_psh, m_pact;
   logic [7:0]     m_dsh [NCH];
   logic [7:0]     m_dact [NCH];
   int             m_e;
   logic           m_pend;
   logic [NCH-1:0] m_pwm;

   typedef struct {
      logic        sel;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_S = '0; m_psh = 8'hFF; m_pact = 8'hFF;
      for (int i = 0; i < NCH; i++) begin m_dsh[i] = '0; m_dact[i] = '0; end
      m_e = 0; m_pend = 1'b0; m_pwm = '0;
   endtask

   task automatic model_step(input logic s, input logic [31:0] a, input logic [3:0] m,
                             input logic [31:0] d);
      logic we, en_new, run, bnd;
      logic [2:0] idx;
      logic [15:0] s_new;
      int len, cnt, ch;
      we = s && (m != 4'h0);
      idx = a[4:2];
      en_new = m_en;
      s_new = m_S;
      if (we && idx == 3'd0) begin
         if (m[0]) en_new = d[0];
         if (m[2]) s_new[7:0] = d[23:16];
         if (m[3]) s_new[15:8] = d[31:24];
      end
      run = m_en && en_new;
      len = (int'(m_pact) + 1) * (int'(m_S) + 1);
      cnt = m_e / (int'(m_S) + 1);
      for (int i = 0; i < NCH; i++) m_pwm[i] = run && (cnt < int'(m_dact[i]));
      bnd = run && (m_e == len - 1);
      if (!run) begin
         m_e = 0; m_pact = m_psh; m_dact = m_dsh; m_pend = 1'b0;
      end else begin
         m_e = bnd ? 0 : m_e + 1;
         if (bnd) begin m_pact = m_psh; m_dact = m_dsh; end
         m_pend = (we && (idx == 3'd1 || idx == 3'd2 || idx == 3'd3)) || (m_pend && !bnd);
      end
      if (we && idx == 3'd1 && m[0]) m_psh = d[7:0];
      if (we && (idx == 3'd2 || idx == 3'd3)) begin
         for (int b = 0; b < 4; b++) begin
            ch = (int'(idx) - 2) * 4 + b;
            if (m[b] && ch < NCH) m_dsh[ch] = d[8*b +: 8];
         end
      end
      m_en = en_new;
      m_S = s_new;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int c;
      c = m_e / (int'(m_S) + 1);
      case (a[4:2])
         3'd0: return {m_S, 15'd0, m_en};
         3'd1: return {24'd0, m_psh};
         3'd2: return {m_dsh[3], m_dsh[2], m_dsh[1], m_dsh[0]};
         3'd3: return {m_dsh[7], m_dsh[6], m_dsh[5], m_dsh[4]};
         3'd4: return {16'd0, 8'(c), 7'd0, m_pend};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] rand_duty();
      return {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
   endfunction

   // One bus cycle: drive on negedge, sample read data before the edge, check pwm after it.
   task automatic bus_cycle(input logic s, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] d, output logic [31:0] rd);
      @(negedge clk);
      sel_in = s; address_in = a; write_mask_in = m; write_value_in = d;
      read_in = s && (m == 4'h0);
      #1;
      rd = read_value_out;
      check("ready", {31'd0, ready_out}, {31'd0, s});
      @(posedge clk);
      model_step(s, a, m, d);
      #1;
      check("pwm_model", {24'd0, pwm_out}, {24'd0, m_pwm});
      sel_in = 1'b0; read_in = 1'b0; write_mask_in = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      logic [31:0] rd;
      bus_cycle(1'b1, a, m, d, rd);
   endtask

   task automatic idle();
      logic [31:0] rd;
      bus_cycle(1'b0, 32'd0, 4'h0, 32'd0, rd);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      bus_cycle(1'b1, a, 4'h0, 32'd0, rd);
      check(name, rd, exp);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1; sel_in = 1'b0; write_mask_in = '0;
         @(posedge clk);
         model_reset();
         #1;
         check("rst_pwm", {24'd0, pwm_out}, 32'd0);
      end
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a, exp, exp_st;
      logic [15:0] psc;
      int r, h1, h2, h3, c0, c1, c2;

      tbl = '{
         '{1'b0, 32'h04, 4'h0, 32'h0,        32'h0},
         '{1'b1, 32'h04, 4'h0, 32'h0,        32'h000000FF},
         '{1'b1, 32'h00, 4'h0, 32'h0,        32'h0},
         '{1'b1, 32'h08, 4'h0, 32'h0,        32'h0},
         '{1'b1, 32'h10, 4'h0, 32'h0,        32'h0},
         '{1'b1, 32'h08, 4'h5, 32'hAABBCCDD, 32'h0},
         '{1'b1, 32'h08, 4'h0, 32'h0,        32'h00BB00DD},
         '{1'b1, 32'h14, 4'hF, 32'hFFFFFFFF, 32'h0},
         '{1'b1, 32'h14, 4'h0, 32'h0,        32'h0},
         '{1'b1, 32'h00, 4'hC, 32'h12345601, 32'h0},
         '{1'b1, 32'h00, 4'h0, 32'h0,        32'h12340000},
         '{1'b1, 32'h0C, 4'hF, 32'h11223344, 32'h0},
         '{1'b1, 32'h0C, 4'h0, 32'h0,        32'h11223344},
         '{1'b1, 32'h04, 4'h2, 32'h000000A5, 32'h0},
         '{1'b1, 32'h04, 4'h0, 32'h0,        32'h000000FF},
         '{1'b1, 32'h00, 4'hF, 32'h0,        32'h0},
         '{1'b1, 32'h1C, 4'h0, 32'h0,        32'h0},
         '{1'b0, 32'h08, 4'h0, 32'h0,        32'h0},
         '{1'b1, 32'h10, 4'h0, 32'h0,        32'h0}
      };

      reset = 1'b1; sel_in = 1'b0; read_in = 1'b0; address_in = '0;
      write_mask_in = '0; write_value_in = '0;
      model_reset();
      do_reset(2);

      // Register table (disabled, so reads are fully determined by the writes above them)
      for (int i = 0; i < 19; i++) begin
         bus_cycle(tbl[i].sel, tbl[i].addr, tbl[i].mask, tbl[i].wdata, rd);
         if (tbl[i].mask == 4'h0) check($sformatf("tbl_%0d", i), rd, tbl[i].exp_rd);
      end

      // Basic PWM: period 4 clocks, ch0 high for 2
      do_reset(1);
      wr(32'h04, 4'hF, 32'd3);
      wr(32'h08, 4'hF, 32'd2);
      wr(32'h00, 4'hF, 32'd1);
      for (int k = 1; k <= 12; k++) begin
         idle();
         check("basic_pwm", {24'd0, pwm_out}, {31'd0, ((k - 1) % 4) < 2});
      end

      // Prescale 1 with duties 0, period, period+1
      wr(32'h00, 4'hF, 32'd0);
      wr(32'h04, 4'hF, 32'd3);
      wr(32'h08, 4'hF, 32'h00040300);
      wr(32'h00, 4'hF, 32'h00010001);
      c0 = 0; c1 = 0; c2 = 0;
      for (int k = 1; k <= 16; k++) begin
         idle();
         c0 += int'(pwm_out[0]); c1 += int'(pwm_out[1]); c2 += int'(pwm_out[2]);
      end
      check("psc_ch0_highs", 32'(c0), 32'd0);
      check("psc_ch1_highs", 32'(c1), 32'd12);
      check("psc_ch2_highs", 32'(c2), 32'd16);

      // Glitch-free duty update: mid-period write, then a write on the boundary cycle
      wr(32'h00, 4'hF, 32'd0);
      wr(32'h04, 4'hF, 32'd9);
      wr(32'h08, 4'hF, 32'd5);
      wr(32'h00, 4'hF, 32'd1);
      h1 = 0; h2 = 0; h3 = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 4) wr(32'h08, 4'h1, 32'd8);
         else if (k == 20) wr(32'h08, 4'h1, 32'd3);
         else if (k == 5 || k == 10 || k == 11 || k == 21 || k == 31) begin
            case (k)
               5:       exp_st = 32'h00000401;
               10:      exp_st = 32'h00000901;
               21:      exp_st = 32'h00000001;
               default: exp_st = 32'h00000000;
            endcase
            rd_chk($sformatf("glitch_status_k%0d", k), 32'h10, exp_st);
         end else idle();
         if (k >= 11 && k <= 20) h1 += int'(pwm_out[0]);
         if (k >= 21 && k <= 30) h2 += int'(pwm_out[0]);
         if (k >= 31 && k <= 40) h3 += int'(pwm_out[0]);
      end
      check("glitch_highs_p1", 32'(h1), 32'd8);
      check("glitch_highs_p2", 32'(h2), 32'd8);
      check("glitch_highs_p3", 32'(h3), 32'd3);

      // Disable mid-period
      idle();
      check("dis_pre_high", {31'd0, pwm_out[0]}, 32'd1);
      wr(32'h00, 4'hF, 32'd0);
      check("dis_pwm", {24'd0, pwm_out}, 32'd0);
      rd_chk("dis_status", 32'h10, 32'd0);

      // Reset mid-period
      wr(32'h0C, 4'hF, 32'hFFFFFFFF);
      wr(32'h00, 4'hF, 32'd1);
      for (int k = 0; k < 4; k++) idle();
      check("rst_pre_pwm", {24'd0, pwm_out}, 32'h000000F0);
      do_reset(1);
      rd_chk("rst_period", 32'h04, 32'h000000FF);
      rd_chk("rst_ctrl",   32'h00, 32'd0);
      rd_chk("rst_duty0",  32'h08, 32'd0);
      rd_chk("rst_duty1",  32'h0C, 32'd0);
      rd_chk("rst_status", 32'h10, 32'd0);

      // Randomized traffic against the reference model
      for (int ep = 0; ep < 6; ep++) begin
         psc = 16'($urandom_range(0, 3));
         wr(32'h00, 4'hF, 32'd0);
         wr(32'h04, 4'hF, 32'($urandom_range(0, 12)));
         wr(32'h08, 4'hF, rand_duty());
         wr(32'h0C, 4'hF, rand_duty());
         wr(32'h00, 4'hF, {psc, 15'd0, 1'b1});
         for (int c = 0; c < 60; c++) begin
            r = $urandom_range(0, 5);
            if (r == 0) begin
               a = 32'($urandom_range(1, 3)) << 2;
               wr(a, 4'($urandom_range(0, 15)), rand_duty());
            end else if (r == 1) begin
               a = 32'($urandom_range(0, 7)) << 2;
               exp = m_read(a);
               bus_cycle(1'b1, a, 4'h0, 32'd0, rd);
               check("rand_read", rd, exp);
            end else idle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
